// File: rtl/pipelined_adder_sub.sv
// Pipelined XLEN-bit adder/subtractor split into STAGES carry segments, with a valid/ready handshake.
// Optional zero/ovf result flags are enabled by defining PIPE_ADDER_FLAGS_EN.
module pipelined_adder_sub #(
  parameter int unsigned XLEN   = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            carry_in,
  input  logic            sub,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN:0]   sum
`ifdef PIPE_ADDER_FLAGS_EN
  ,
  output logic            zero,
  output logic            ovf
`endif
);

  localparam int unsigned W    = XLEN / STAGES;
  localparam int unsigned LAST = STAGES - 1;

  logic advance;

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned RW = (STAGES - k) * W;

    // op_a/op_b hold only the operand bits not yet summed; the low W bits are this segment.
    logic [RW-1:0]        op_a;
    logic [RW-1:0]        op_b;
    logic                 seg_cin;
    logic                 seg_vld;
    logic [W:0]           seg;
    logic [(k+1)*W-1:0]   part;

    logic                 v_q;
    logic                 c_q;
    logic [(k+1)*W-1:0]   s_q;

    if (k == 0) begin : g_in
      assign op_a    = a;
      assign op_b    = sub ? ~b : b;
      assign seg_cin = sub | carry_in;
      assign seg_vld = in_valid;
      assign part    = seg[W-1:0];
    end else begin : g_link
      assign op_a    = g_stage[k-1].g_fwd.a_q;
      assign op_b    = g_stage[k-1].g_fwd.b_q;
      assign seg_cin = g_stage[k-1].c_q;
      assign seg_vld = g_stage[k-1].v_q;
      assign part    = {seg[W-1:0], g_stage[k-1].s_q};
    end

    assign seg = {1'b0, op_a[W-1:0]} + {1'b0, op_b[W-1:0]} + {{W{1'b0}}, seg_cin};

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (advance) begin
        v_q <= seg_vld;
        c_q <= seg[W];
        s_q <= part;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [RW-W-1:0] a_q;
      logic [RW-W-1:0] b_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= op_a[RW-1:W];
          b_q <= op_b[RW-1:W];
        end
      end
    end
  end

  assign out_valid = g_stage[LAST].v_q;
  assign sum       = {g_stage[LAST].c_q, g_stage[LAST].s_q};

`ifdef PIPE_ADDER_FLAGS_EN
  logic zero_q;
  logic ovf_q;

  // Carry into the MSB is recovered as a^b'^s at that bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (advance) begin
      zero_q <= (g_stage[LAST].part == '0);
      ovf_q  <= g_stage[LAST].seg[W] ^ g_stage[LAST].op_a[W-1] ^ g_stage[LAST].op_b[W-1]
                ^ g_stage[LAST].seg[W-1];
    end
  end

  assign zero = zero_q;
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder_sub.sv
// Bench for pipelined_adder_sub: three depths (4, 1, 16) share one stimulus bus, each scoreboarded
// against an arithmetic model. Define PIPE_ADDER_FLAGS_EN to also check zero/ovf.
module tb_pipelined_adder_sub;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic        carry_in;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;

  logic        in_rdy  [N];
  logic        out_vld [N];
  logic [16:0] sm      [N];
`ifdef PIPE_ADDER_FLAGS_EN
  logic        zr      [N];
  logic        ofl     [N];
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int n_deliv  = 0;

  logic [18:0] exp_q    [N][$];
  logic        held     [N];
  logic [16:0] held_sum [N];

  always #5 clk = ~clk;

  pipelined_adder_sub #(.XLEN(16), .STAGES(4)) u_s4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_rdy[0]), .a(a), .b(b),
    .carry_in(carry_in), .sub(sub), .out_valid(out_vld[0]), .out_ready(out_ready), .sum(sm[0])
`ifdef PIPE_ADDER_FLAGS_EN
    , .zero(zr[0]), .ovf(ofl[0])
`endif
  );

  pipelined_adder_sub #(.XLEN(16), .STAGES(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_rdy[1]), .a(a), .b(b),
    .carry_in(carry_in), .sub(sub), .out_valid(out_vld[1]), .out_ready(out_ready), .sum(sm[1])
`ifdef PIPE_ADDER_FLAGS_EN
    , .zero(zr[1]), .ovf(ofl[1])
`endif
  );

  pipelined_adder_sub #(.XLEN(16), .STAGES(16)) u_s16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_rdy[2]), .a(a), .b(b),
    .carry_in(carry_in), .sub(sub), .out_valid(out_vld[2]), .out_ready(out_ready), .sum(sm[2])
`ifdef PIPE_ADDER_FLAGS_EN
    , .zero(zr[2]), .ovf(ofl[2])
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Returns {zero, ovf, carry/borrow, sum[15:0]} from plain integer arithmetic.
  function automatic logic [18:0] model_op(input logic [15:0] x, input logic [15:0] y,
                                           input logic ci, input logic s);
    int          sx;
    int          sy;
    int          r;
    int          u;
    logic [16:0] res;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (s) begin
      u   = int'(x) - int'(y);
      res = {x >= y, u[15:0]};
      r   = sx - sy;
    end else begin
      u   = int'(x) + int'(y) + int'(ci);
      res = u[16:0];
      r   = sx + sy + int'(ci);
    end
    return {res[15:0] == 16'h0, (r > 32767) || (r < -32768), res};
  endfunction

  // Scoreboard: observe each handshake half a cycle before the edge that completes it.
  initial begin
    logic [18:0] e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (rst) begin
          exp_q[i].delete();
          held[i] = 1'b0;
        end else begin
          check($sformatf("in_ready[%0d]", i), in_rdy[i], !out_vld[i] || out_ready);
          if (held[i]) begin
            check($sformatf("hold_valid[%0d]", i), out_vld[i], 1);
            check($sformatf("hold_sum[%0d]", i), sm[i], held_sum[i]);
          end
          if (out_vld[i] && out_ready) begin
            if (exp_q[i].size() == 0) begin
              check($sformatf("stale_out[%0d]", i), out_vld[i], 0);
            end else begin
              e = exp_q[i].pop_front();
              check($sformatf("sum[%0d]", i), sm[i], e[16:0]);
`ifdef PIPE_ADDER_FLAGS_EN
              check($sformatf("zero[%0d]", i), zr[i], e[18]);
              check($sformatf("ovf[%0d]", i), ofl[i], e[17]);
`endif
            end
            if (i == 0) n_deliv++;
          end
          if (in_valid && in_rdy[i]) exp_q[i].push_back(model_op(a, b, carry_in, sub));
          held[i]     = out_vld[i] && !out_ready;
          held_sum[i] = sm[i];
        end
      end
    end
  end

  task automatic op_single(input logic [15:0] x, input logic [15:0] y, input logic ci,
                           input logic s, input logic [16:0] exp_sum, input logic exp_zero,
                           input logic exp_ovf, input string tag);
    @(posedge clk);
    #1;
    a         = x;
    b         = y;
    carry_in  = ci;
    sub       = s;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check({tag, "_lat0"}, out_vld[0], 0);
    for (int i = 1; i < 4; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("%s_lat%0d", tag, i), out_vld[0], i == 3);
    end
    check(tag, sm[0], exp_sum);
`ifdef PIPE_ADDER_FLAGS_EN
    check({tag, "_zero"}, zr[0], exp_zero);
    check({tag, "_ovf"}, ofl[0], exp_ovf);
`endif
  endtask

  task automatic idle(input int cycles);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [15:0] sa [6];
    logic [15:0] sb [6];
    logic        acc;
    int          idx;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    carry_in  = 1'b0;
    sub       = 1'b0;
    a         = '0;
    b         = '0;
    @(posedge clk);
    #1;
    check("rst_in_ready", in_rdy[0], 1);
    check("rst_out_valid", out_vld[0], 0);
    check("rst_sum", sm[0], 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    op_single(16'h00FF, 16'h0001, 1'b0, 1'b0, 17'h00100, 1'b0, 1'b0, "add_basic");
    op_single(16'hFFFF, 16'h0000, 1'b1, 1'b0, 17'h10000, 1'b1, 1'b0, "carry_ripple");
    op_single(16'h0005, 16'h0007, 1'b1, 1'b1, 17'h0FFFE, 1'b0, 1'b0, "sub_borrow");
    op_single(16'h0007, 16'h0005, 1'b0, 1'b1, 17'h10002, 1'b0, 1'b0, "sub_noborrow");
    op_single(16'h8000, 16'h0001, 1'b0, 1'b1, 17'h17FFF, 1'b0, 1'b1, "sub_ovf");

    // Back-to-back issue, then back-pressure from cycle 5 until cycle 12.
    idle(20);
    n_deliv = 0;
    for (int i = 0; i < 6; i++) begin
      sa[i] = 16'($urandom);
      sb[i] = 16'($urandom);
    end
    idx = 0;
    for (int c = 0; c < 30; c++) begin
      in_valid  = idx < 6;
      a         = sa[idx % 6];
      b         = sb[idx % 6];
      carry_in  = 1'(idx);
      sub       = idx > 2;
      out_ready = (c < 5) || (c >= 12);
      @(negedge clk);
      acc = in_valid && in_rdy[0];
      if (c >= 6 && c < 12) begin
        check("stall_in_ready", in_rdy[0], 0);
        check("stall_out_valid", out_vld[0], 1);
      end
      @(posedge clk);
      #1;
      if (acc) idx++;
    end
    check("stall_accepts", idx, 6);
    check("stall_delivered", n_deliv, 6);

    // Reset with three operations in flight, the oldest already at the output.
    idle(20);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a        = 16'($urandom);
      b        = 16'($urandom) | 16'h0001;
      carry_in = 1'b1;
      sub      = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    check("pre_rst_valid", out_vld[0], 1);
    rst = 1'b1;
    #1;
    check("rst_flush_valid", out_vld[0], 0);
    check("rst_flush_sum", sm[0], 0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("post_rst_quiet", out_vld[0], 0);
    end
    op_single(16'h1234, 16'h4321, 1'b1, 1'b0, 17'h05556, 1'b0, 1'b0, "post_rst_add");

    // Random traffic with random back-pressure on all three depths.
    for (int c = 0; c < 10000; c++) begin
      in_valid  = $urandom_range(0, 9) < 7;
      out_ready = $urandom_range(0, 9) < 7;
      carry_in  = 1'($urandom);
      sub       = 1'($urandom);
      case ($urandom_range(0, 7))
        0:       a = 16'hFFFF;
        1:       a = 16'h8000;
        default: a = 16'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0:       b = 16'h0000;
        1:       b = a;
        default: b = 16'($urandom);
      endcase
      @(posedge clk);
      #1;
    end
    idle(40);
    for (int i = 0; i < N; i++) check($sformatf("drain_empty[%0d]", i), exp_q[i].size(), 0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
